key_debounce_multi: RTL and testbench

//  Parametrised N-channel push-button conditioner for the detonator keypad/control keys.
//  Per channel: 2-flop input synchroniser, press and release debounce, stable level,
//  one-cycle press/release pulses, optional hold-to-repeat pulses.

---
 rtl/key_debounce_multi.sv | 203 ++++++++++++++++++++
 tb/tb_key_debounce_multi.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: per-channel 2-flop synchroniser,
// press/release debounce FSM, stable level, edge pulses and hold-to-repeat.
module key_debounce_multi #(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned KEY_ACT_LOW = 1,
  parameter int unsigned DEB_W       = 7,
  parameter int unsigned DEB_CNT     = 125,
  parameter int unsigned HOLD_W      = 16,
  parameter int unsigned REPEAT_EN   = 1,
  parameter int unsigned HOLD_CNT    = 5000,
  parameter int unsigned REPEAT_CNT  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              any_press
);

  // One spare bit so HOLD_CNT + REPEAT_CNT always fits in the hold counter.
  localparam int unsigned HC_W = HOLD_W + 1;

  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CNT - 1);
  localparam logic [HC_W-1:0]   HOLD_FIRST = HC_W'(HOLD_CNT);
  localparam logic [HC_W-1:0]   HOLD_TOP   = HC_W'(HOLD_CNT + REPEAT_CNT);
  localparam logic [N_KEYS-1:0] IDLE_PINS  = (KEY_ACT_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_REL_WAIT
  } state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] act_c;
  logic [N_KEYS-1:0] press_d_c;
  logic              any_press_q;

  // Two-flop synchroniser; reset loads the released pin level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_PINS;
      sync2_q <= IDLE_PINS;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  assign act_c = (KEY_ACT_LOW != 0) ? ~sync2_q : sync2_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             hold_clr;
    logic             hold_inc;

    // Debounce FSM state and registered level/pulse outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        deb_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        deb_q   <= deb_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // Next-state: a new level must persist DEB_CNT samples to be accepted.
    always_comb begin
      state_d  = state_q;
      deb_d    = deb_q;
      level_d  = level_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      hold_clr = 1'b0;
      hold_inc = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          deb_d = '0;
          if (act_c[i]) begin
            state_d = ST_PRESS_WAIT;
            deb_d   = DEB_W'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!act_c[i]) begin
            state_d = ST_IDLE;
            deb_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d  = ST_PRESSED;
            deb_d    = '0;
            press_d  = 1'b1;
            level_d  = 1'b1;
            hold_clr = 1'b1;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!act_c[i]) begin
            state_d = ST_REL_WAIT;
            deb_d   = DEB_W'(1);
          end else begin
            hold_inc = 1'b1;
          end
        end
        ST_REL_WAIT: begin
          // A return to active is bounce: back to PRESSED, hold time frozen.
          if (act_c[i]) begin
            state_d = ST_PRESSED;
            deb_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d = ST_IDLE;
            deb_d   = '0;
            rel_d   = 1'b1;
            level_d = 1'b0;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          deb_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign key_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign press_d_c[i]     = press_d;

    if (REPEAT_EN != 0) begin : g_rep
      logic [HC_W-1:0] hold_q, hold_d;
      logic [HC_W-1:0] hold_inc_c;
      logic            rep_q, rep_d;

      // Hold counter and registered repeat pulse.
      always_ff @(posedge clk) begin
        if (rst) begin
          hold_q <= '0;
          rep_q  <= 1'b0;
        end else begin
          hold_q <= hold_d;
          rep_q  <= rep_d;
        end
      end

      assign hold_inc_c = hold_q + HC_W'(1);

      // First pulse at HOLD_CNT, then every REPEAT_CNT by reloading from the top.
      always_comb begin
        hold_d = hold_q;
        rep_d  = 1'b0;
        if (hold_clr) begin
          hold_d = '0;
        end else if (hold_inc) begin
          if (hold_inc_c == HOLD_TOP) begin
            hold_d = HOLD_FIRST;
            rep_d  = 1'b1;
          end else begin
            hold_d = hold_inc_c;
            rep_d  = (hold_inc_c == HOLD_FIRST);
          end
        end
      end

      assign repeat_pulse[i] = rep_q;
    end else begin : g_no_rep
      logic unused_hold_c;
      assign unused_hold_c   = hold_clr ^ hold_inc;
      assign repeat_pulse[i] = 1'b0;
    end
  end

  // Aggregate press flag, aligned with the per-channel press pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_d_c;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random key activity,
// every cycle compared against a history-based reference model.
module tb_key_debounce_multi;

  localparam int NK   = 4;
  localparam int DEB  = 8;
  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] repeat_pulse;
  logic          any_press;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .N_KEYS(NK), .KEY_ACT_LOW(1), .DEB_W(7), .DEB_CNT(DEB), .HOLD_W(16),
    .REPEAT_EN(1), .HOLD_CNT(HOLD), .REPEAT_CNT(REP)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .key_level(key_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .any_press(any_press)
  );

  // Reference model: a level flips once the last DEB samples all disagree with it;
  // held time counts samples that are active, preceded by active, while pressed.
  logic [NK-1:0]  m_s1, m_s2, m_lvl, m_prev;
  logic [NK-1:0]  e_press, e_rel, e_rep;
  logic           e_any;
  logic [DEB-1:0] m_hist [NK];
  int             m_cnt [NK];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic a;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
      e_press = '0; e_rel = '0; e_rep = '0; e_any = 1'b0;
      for (int ch = 0; ch < NK; ch++) begin
        m_hist[ch] = '0;
        m_cnt[ch]  = 0;
      end
    end else begin
      e_press = '0; e_rel = '0; e_rep = '0;
      for (int ch = 0; ch < NK; ch++) begin
        a = m_s2[ch];
        m_hist[ch] = {m_hist[ch][DEB-2:0], a};
        if (!m_lvl[ch] && (m_hist[ch] == '1)) begin
          m_lvl[ch]   = 1'b1;
          e_press[ch] = 1'b1;
          m_cnt[ch]   = 0;
        end else if (m_lvl[ch] && (m_hist[ch] == '0)) begin
          m_lvl[ch] = 1'b0;
          e_rel[ch] = 1'b1;
        end else if (m_lvl[ch] && a && m_prev[ch]) begin
          m_cnt[ch]++;
          if (m_cnt[ch] >= HOLD && ((m_cnt[ch] - HOLD) % REP) == 0) e_rep[ch] = 1'b1;
        end
        m_prev[ch] = a;
      end
      e_any = |e_press;
      m_s2  = m_s1;
      m_s1  = ~key;
    end
  endtask

  // One clock with given pins/reset, then compare every output with the model.
  task automatic step(input logic [NK-1:0] k, input logic r);
    key = k;
    rst = r;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("key_level", key_level, m_lvl);
    check("press_pulse", press_pulse, e_press);
    check("release_pulse", release_pulse, e_rel);
    check("repeat_pulse", repeat_pulse, e_rep);
    check("any_press", {{(NK-1){1'b0}}, any_press}, {{(NK-1){1'b0}}, e_any});
  endtask

  initial begin
    logic [NK-1:0] k;
    int lat, lat3, cnt, cnt_any;

    // Reset with all keys released.
    for (int s = 0; s < 3; s++) step('1, 1'b1);
    check("reset_outputs", key_level | press_pulse | release_pulse | repeat_pulse, '0);
    for (int s = 0; s < 12; s++) step('1, 1'b0);

    // key[0] held low: press and level at the 10th cycle.
    k = 4'b1110;
    lat = -1;
    for (int s = 1; s <= 20; s++) begin
      step(k, 1'b0);
      if (press_pulse[0] && lat < 0) lat = s;
    end
    check_int("press_latency_k0", lat, DEB + 2);

    // key[1] bounce of 5 cycles is rejected.
    cnt = 0;
    for (int s = 0; s < 5; s++) begin
      step(k & 4'b1101, 1'b0);
      cnt += int'(press_pulse[1]);
    end
    for (int s = 0; s < 15; s++) begin
      step(k, 1'b0);
      cnt += int'(press_pulse[1]);
    end
    check_int("bounce_no_press_k1", cnt, 0);
    check_int("bounce_level_k1", int'(key_level[1]), 0);

    // key[2] held 60 cycles after acceptance: 9 repeat pulses.
    k = 4'b1010;
    lat = -1;
    for (int s = 1; s <= 20 && lat < 0; s++) begin
      step(k, 1'b0);
      if (press_pulse[2]) lat = s;
    end
    check_int("press_latency_k2", lat, DEB + 2);
    cnt = 0;
    for (int s = 1; s <= 60; s++) begin
      step(k, 1'b0);
      cnt += int'(repeat_pulse[2]);
    end
    check_int("repeat_count_k2", cnt, 9);
    k = 4'b1110;
    for (int s = 0; s < 15; s++) step(k, 1'b0);

    // key[0] release with a 3-cycle bounce, then steady high.
    cnt = 0;
    for (int s = 0; s < 3; s++) begin step(4'b1111, 1'b0); cnt += int'(release_pulse[0]); end
    for (int s = 0; s < 2; s++) begin step(4'b1110, 1'b0); cnt += int'(release_pulse[0]); end
    lat = -1;
    for (int s = 1; s <= 20; s++) begin
      step(4'b1111, 1'b0);
      cnt += int'(release_pulse[0]);
      if (release_pulse[0] && lat < 0) lat = s;
    end
    check_int("release_latency_k0", lat, DEB + 2);
    check_int("release_count_k0", cnt, 1);

    // key[0] and key[3] together: both pulses, any_press once.
    lat = -1; lat3 = -1; cnt_any = 0;
    for (int s = 1; s <= 20; s++) begin
      step(4'b0110, 1'b0);
      if (press_pulse[0] && lat < 0) lat = s;
      if (press_pulse[3] && lat3 < 0) lat3 = s;
      cnt_any += int'(any_press);
    end
    check_int("dual_press_k0", lat, DEB + 2);
    check_int("dual_press_k3", lat3, DEB + 2);
    check_int("dual_any_press", cnt_any, 1);
    for (int s = 0; s < 15; s++) step('1, 1'b0);

    // Reset while key[2] is pressed, then a fresh press after reset.
    for (int s = 0; s < 14; s++) step(4'b1011, 1'b0);
    check_int("pre_reset_level_k2", int'(key_level[2]), 1);
    step(4'b1011, 1'b1);
    check("rst_outputs", key_level | press_pulse | release_pulse | repeat_pulse, '0);
    check_int("rst_any_press", int'(any_press), 0);
    lat = -1; cnt = 0;
    for (int s = 1; s <= 20; s++) begin
      step(4'b1011, 1'b0);
      if (press_pulse[2] && lat < 0) lat = s;
      cnt += int'(release_pulse[2]);
    end
    check_int("post_reset_press_k2", lat, DEB + 2);
    check_int("post_reset_no_release", cnt, 0);

    // Random activity: bouncy phase, then long holds, with rare resets.
    k = '1;
    for (int s = 0; s < 600; s++) begin
      for (int ch = 0; ch < NK; ch++)
        if ($urandom_range(5, 0) == 0) k[ch] = ~k[ch];
      step(k, ($urandom_range(299, 0) == 0));
    end
    for (int s = 0; s < 1500; s++) begin
      for (int ch = 0; ch < NK; ch++)
        if ($urandom_range(39, 0) == 0) k[ch] = ~k[ch];
      step(k, ($urandom_range(499, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
